// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column, samples the synchronised rows,
// debounces over whole scans and emits one event per accepted single-key press.
//
// state | meaning
// IDLE  | no key accepted; waiting for a debounced single-key press
// HELD  | a press was accepted; waiting for a debounced all-keys release
module keypad_scan #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_down
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [1:0] RES_NONE   = 2'd0;
   localparam logic [1:0] RES_SINGLE = 2'd1;
   localparam logic [1:0] RES_MULTI  = 2'd2;

   typedef enum logic {IDLE, HELD} state_t;

   state_t          state, state_nx;
   logic [3:0]      row_s1, row_s2;
   logic            active;
   logic [DW-1:0]   div_cnt;
   logic [1:0]      col;
   logic [15:0]     snapshot;
   logic [15:0]     full_scan;
   logic [CW-1:0]   stable_cnt, cnt_nx;
   logic [5:0]      prev_res, res_word;
   logic [1:0]      res_kind;
   logic [3:0]      res_code, hit_idx;
   logic [4:0]      hit_cnt;
   logic            sample, eval, accept;

   assign sample    = active && (div_cnt == DW'(SCAN_DIV - 1));
   assign eval      = sample && (col == 2'd3);
   // Column 3 is being written on the evaluation cycle, so take it straight from the synchroniser.
   assign full_scan = {~row_s2, snapshot[11:0]};
   assign col_out   = active ? ~(4'b0001 << col) : 4'hF;
   assign key_down  = (state == HELD);
   assign res_word  = {res_kind, res_code};

   always_comb begin
      hit_cnt = '0;
      hit_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (full_scan[i]) begin
            hit_cnt = hit_cnt + 5'd1;
            hit_idx = 4'(i);
         end
      end
      res_kind = RES_MULTI;
      res_code = '0;
      if (hit_cnt == 5'd0) begin
         res_kind = RES_NONE;
      end else if (hit_cnt == 5'd1) begin
         res_kind = RES_SINGLE;
         res_code = hit_idx;
      end
      if (res_word == prev_res) begin
         cnt_nx = (stable_cnt == CW'(DEBOUNCE_SCANS)) ? stable_cnt : stable_cnt + 1'b1;
      end else begin
         cnt_nx = CW'(1);
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      if (!en) begin
         state_nx = IDLE;
      end else if (eval) begin
         case (state)
            IDLE: if (res_kind == RES_SINGLE && cnt_nx == CW'(DEBOUNCE_SCANS)) begin
               state_nx = HELD;
               accept   = 1'b1;
            end
            HELD: if (res_kind == RES_NONE && cnt_nx == CW'(DEBOUNCE_SCANS)) begin
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1     <= 4'hF;
         row_s2     <= 4'hF;
         active     <= 1'b0;
         div_cnt    <= '0;
         col        <= '0;
         snapshot   <= '0;
         stable_cnt <= '0;
         prev_res   <= '0;
         key_valid  <= 1'b0;
         key_code   <= '0;
      end else begin
         row_s1 <= row_in;
         row_s2 <= row_s1;
         if (!en) begin
            // Parking discards any partial scan; the last accepted code stays visible.
            active     <= 1'b0;
            div_cnt    <= '0;
            col        <= '0;
            snapshot   <= '0;
            stable_cnt <= '0;
            prev_res   <= '0;
            key_valid  <= 1'b0;
         end else begin
            active    <= 1'b1;
            key_valid <= accept;
            if (active) begin
               if (sample) begin
                  div_cnt                     <= '0;
                  col                         <= col + 2'd1;
                  snapshot[{col, 2'b00} +: 4] <= ~row_s2;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            if (eval) begin
               stable_cnt <= cnt_nx;
               prev_res   <= res_word;
            end
            if (accept) key_code <= res_code;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix schedule drives a keypad model, and a per-scan
// reference model predicts key_valid/key_down/key_code/col_out for every cycle.
module tb_keypad_scan;
   localparam int MAXC = 1024;
   localparam int SCAN = 16;
   localparam int DEB  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic [3:0]  row_in, col_out, key_code;
   logic        key_valid, key_down;
   logic [15:0] keys = '0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] sched [MAXC];
   logic        ov [MAXC], od [MAXC], ev [MAXC], ed [MAXC];
   logic [3:0]  oc [MAXC], ocol [MAXC], ec [MAXC], ecol [MAXC];
   logic        clr_v, clr_d;
   logic [3:0]  clr_c, clr_col;

   always #5 clk = ~clk;

   always_comb begin
      row_in = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
   end

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DEB)) dut (
      .clk(clk), .rst(rst), .en(en), .row_in(row_in), .col_out(col_out),
      .key_valid(key_valid), .key_code(key_code), .key_down(key_down)
   );

   // Clear (rst or en low) for one cycle, then play sched[0..n-1]; cycle 0 is the first scanning cycle.
   task automatic run(input int n, input bit use_en);
      keys = sched[0];
      if (use_en) en = 1'b0;
      else        rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_v = key_valid; clr_d = key_down; clr_c = key_code; clr_col = col_out;
      rst = 1'b0;
      en  = 1'b1;
      for (int t = 0; t < n; t++) begin
         @(posedge clk);
         #1 keys = sched[t];
         @(negedge clk);
         ov[t] = key_valid; od[t] = key_down; oc[t] = key_code; ocol[t] = col_out;
      end
   endtask

   // Each scan sees the key matrix as it stood one cycle into each column's dwell.
   task automatic model(input int n, input logic [3:0] code0);
      int          prev = -2;
      int          cnt  = 0;
      int          res, ones, s;
      bit          held = 1'b0;
      bit          pulse;
      logic [3:0]  code = code0;
      logic [3:0]  one  = 4'b0001;
      logic [15:0] m;
      for (int t = 0; t < n; t++) begin
         pulse = 1'b0;
         if (t >= SCAN && t % SCAN == 0) begin
            s = t / SCAN - 1;
            m = '0;
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  if (sched[SCAN*s + 4*c + 1][c*4+r]) m[c*4+r] = 1'b1;
            ones = 0;
            res  = -1;
            for (int i = 0; i < 16; i++) if (m[i]) begin ones++; res = i; end
            if (ones >= 2) res = 16;
            cnt  = (res == prev) ? ((cnt < DEB) ? cnt + 1 : DEB) : 1;
            prev = res;
            if (!held && res >= 0 && res < 16 && cnt == DEB) begin
               held  = 1'b1;
               code  = res[3:0];
               pulse = 1'b1;
            end else if (held && res == -1 && cnt == DEB) begin
               held = 1'b0;
            end
         end
         ev[t] = pulse; ed[t] = held; ec[t] = code;
         ecol[t] = ~(one << ((t / 4) % 4));
      end
   endtask

   task automatic test_reset();
      logic [3:0] cols [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      keys = '0;
      rst  = 1'b1;
      en   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_tests++;
         if ({col_out, key_valid, key_code, key_down} !== {4'hF, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset cyc=%0d got col/v/code/d=%h/%b/%h/%b exp F/0/0/0",
                     i, col_out, key_valid, key_code, key_down);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < SCAN; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_tests++;
         if ({col_out, key_valid} !== {cols[i/4], 1'b0}) begin
            n_fail++;
            $display("FAIL scan_order cyc=%0d got col/v=%h/%b exp %h/0", i, col_out, key_valid, cols[i/4]);
         end
      end
   endtask

   task automatic test_single();
      int n = 300, lf = 0, pulses = 0, first = -1;
      for (int t = 0; t < n; t++) sched[t] = 16'h0200;
      run(n, 1'b0);
      model(n, 4'h0);
      for (int t = 0; t < n; t++) begin
         n_tests++;
         if ({ov[t], od[t], oc[t], ocol[t]} !== {ev[t], ed[t], ec[t], ecol[t]}) begin
            n_fail++;
            if (lf++ < 4) $display("FAIL single t=%0d got v/d/code/col=%b/%b/%h/%h exp %b/%b/%h/%h",
                                   t, ov[t], od[t], oc[t], ocol[t], ev[t], ed[t], ec[t], ecol[t]);
         end
         if (ov[t]) begin pulses++; if (first < 0) first = t; end
      end
      n_tests++;
      if (pulses != 1 || first != 48 || oc[n-1] !== 4'h9 || od[n-1] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_event got pulses=%0d at=%0d code=%h down=%b exp 1/48/9/1",
                  pulses, first, oc[n-1], od[n-1]);
      end
   endtask

   task automatic test_bounce();
      int n = 400, lf = 0;
      int phase = int'($urandom_range(0, 15));
      for (int t = 0; t < n; t++) begin
         if (t < phase)            sched[t] = '0;
         else if (t < phase + 100) sched[t] = (((t - phase) / 10) % 2 == 0) ? 16'h0008 : 16'h0000;
         else                      sched[t] = 16'h0008;
      end
      run(n, 1'b0);
      model(n, 4'h0);
      for (int t = 0; t < n; t++) begin
         n_tests++;
         if ({ov[t], od[t], oc[t], ocol[t]} !== {ev[t], ed[t], ec[t], ecol[t]}) begin
            n_fail++;
            if (lf++ < 4) $display("FAIL bounce t=%0d got v/d/code/col=%b/%b/%h/%h exp %b/%b/%h/%h",
                                   t, ov[t], od[t], oc[t], ocol[t], ev[t], ed[t], ec[t], ecol[t]);
         end
      end
      n_tests++;
      if (oc[n-1] !== 4'h3 || od[n-1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_final got code=%h down=%b exp 3/1", oc[n-1], od[n-1]);
      end
   endtask

   task automatic test_release();
      int lf = 0, pulses = 0, bad_code = 0;
      int k  = int'($urandom_range(0, 15));
      int h1 = 70 + int'($urandom_range(0, 40));
      int g  = 70 + int'($urandom_range(0, 40));
      int n  = h1 + g + 120;
      logic [15:0] one = 16'h0001;
      for (int t = 0; t < n; t++) sched[t] = (t < h1 || t >= h1 + g) ? (one << k) : 16'h0000;
      run(n, 1'b0);
      model(n, 4'h0);
      for (int t = 0; t < n; t++) begin
         n_tests++;
         if ({ov[t], od[t], oc[t], ocol[t]} !== {ev[t], ed[t], ec[t], ecol[t]}) begin
            n_fail++;
            if (lf++ < 4) $display("FAIL release t=%0d got v/d/code/col=%b/%b/%h/%h exp %b/%b/%h/%h",
                                   t, ov[t], od[t], oc[t], ocol[t], ev[t], ed[t], ec[t], ecol[t]);
         end
         if (ov[t]) begin pulses++; if (oc[t] !== 4'(k)) bad_code++; end
      end
      n_tests++;
      if (pulses != 2 || bad_code != 0 || od[h1 + g - 1] !== 1'b0) begin
         n_fail++;
         $display("FAIL repress got pulses=%0d badcode=%0d down_in_gap=%b exp 2/0/0",
                  pulses, bad_code, od[h1 + g - 1]);
      end
   endtask

   task automatic test_multi();
      int n = 560, lf = 0, pulses = 0, down_a = 0;
      for (int t = 0; t < n; t++) begin
         if (t < 150)      sched[t] = 16'h8001;
         else if (t < 200) sched[t] = 16'h0000;
         else if (t < 280) sched[t] = 16'h0040;
         else if (t < 440) sched[t] = 16'h8040;
         else              sched[t] = 16'h0000;
      end
      run(n, 1'b0);
      model(n, 4'h0);
      for (int t = 0; t < n; t++) begin
         n_tests++;
         if ({ov[t], od[t], oc[t], ocol[t]} !== {ev[t], ed[t], ec[t], ecol[t]}) begin
            n_fail++;
            if (lf++ < 4) $display("FAIL multi t=%0d got v/d/code/col=%b/%b/%h/%h exp %b/%b/%h/%h",
                                   t, ov[t], od[t], oc[t], ocol[t], ev[t], ed[t], ec[t], ecol[t]);
         end
         if (ov[t]) pulses++;
         if (t < 200 && od[t] !== 1'b0) down_a++;
      end
      n_tests++;
      if (pulses != 1 || down_a != 0 || oc[n-1] !== 4'h6 || od[439] !== 1'b1 || od[n-1] !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_event got pulses=%0d down_idle=%0d code=%h held=%b rel=%b exp 1/0/6/1/0",
                  pulses, down_a, oc[n-1], od[439], od[n-1]);
      end
   endtask

   // Park mid-column 2 while HELD (via rst or en), then check the clear and the fresh scan.
   task automatic test_mid_clear(input bit use_en);
      int n1 = 5*SCAN + 11, n = 200, lf = 0, first = -1;
      int k = int'($urandom_range(0, 15));
      logic [15:0] one = 16'h0001;
      logic [3:0]  exp_c = use_en ? 4'(k) : 4'h0;
      for (int t = 0; t < n; t++) sched[t] = one << k;
      run(n1, 1'b0);
      n_tests++;
      if (od[n1-1] !== 1'b1 || oc[n1-1] !== 4'(k)) begin
         n_fail++;
         $display("FAIL pre_clear got down=%b code=%h exp 1/%h", od[n1-1], oc[n1-1], 4'(k));
      end
      run(n, use_en);
      n_tests++;
      if ({clr_col, clr_v, clr_d, clr_c} !== {4'hF, 1'b0, 1'b0, exp_c}) begin
         n_fail++;
         $display("FAIL clear_cycle en_mode=%0d got col/v/d/code=%h/%b/%b/%h exp F/0/0/%h",
                  use_en, clr_col, clr_v, clr_d, clr_c, exp_c);
      end
      model(n, exp_c);
      for (int t = 0; t < n; t++) begin
         n_tests++;
         if ({ov[t], od[t], oc[t], ocol[t]} !== {ev[t], ed[t], ec[t], ecol[t]}) begin
            n_fail++;
            if (lf++ < 4) $display("FAIL after_clear t=%0d got v/d/code/col=%b/%b/%h/%h exp %b/%b/%h/%h",
                                   t, ov[t], od[t], oc[t], ocol[t], ev[t], ed[t], ec[t], ecol[t]);
         end
         if (ov[t] && first < 0) first = t;
      end
      n_tests++;
      if (first != 48) begin
         n_fail++;
         $display("FAIL repulse_time en_mode=%0d got %0d exp 48", use_en, first);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         int n = 500, lf = 0, t = 0, len, nk;
         logic [15:0] m, one = 16'h0001;
         while (t < n) begin
            len = int'($urandom_range(10, 90));
            nk  = int'($urandom_range(0, 2));
            m   = '0;
            for (int j = 0; j < nk; j++) m = m | (one << $urandom_range(0, 15));
            for (int j = 0; j < len && t < n; j++) sched[t++] = m;
         end
         run(n, 1'b0);
         model(n, 4'h0);
         for (int u = 0; u < n; u++) begin
            n_tests++;
            if ({ov[u], od[u], oc[u], ocol[u]} !== {ev[u], ed[u], ec[u], ecol[u]}) begin
               n_fail++;
               if (lf++ < 4) $display("FAIL random it=%0d t=%0d got v/d/code/col=%b/%b/%h/%h exp %b/%b/%h/%h",
                                      it, u, ov[u], od[u], oc[u], ocol[u], ev[u], ed[u], ec[u], ecol[u]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_bounce();
      test_release();
      test_multi();
      test_mid_clear(1'b0);
      test_mid_clear(1'b1);
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
